sel_sort_engine: RTL
====================

SEL_SORT_ENGINE -- requirements
Module: sel_sort_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, key width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (>=2); IDX_W = $clog2(DEPTH), derived locally.
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  sort request, sampled only in IDLE or DONE.
REQ-006 SHALL have port desc  input  1  order select (0 ascending, 1 descending), sampled with accepted start.
REQ-007 SHALL have port wr_en  input  1  host write strobe.
REQ-008 SHALL have port wr_addr  input  IDX_W  host write index.
REQ-009 SHALL have port wr_data  input  DATA_W  host write value.
REQ-010 SHALL have port rd_addr  input  IDX_W  host read index.
REQ-011 SHALL have port rd_data  output  DATA_W  combinational mem[rd_addr], valid in every state.
REQ-012 SHALL have port busy  output  1  high while a sort is in progress.
REQ-013 SHALL have port done  output  1  level, high in DONE.
REQ-014 SHALL have port swap_cnt  output  16  swaps performed in last/current sort.
REQ-015 SHALL have port cmp_cnt  output  16  comparisons performed in last/current sort.

Function
REQ-016 SHALL implement true selection sort: per pass i, scan j=i+1..DEPTH-1 for the extreme key, then perform at most one swap.
REQ-017 SHALL use FSM states IDLE, PASS_INIT, SCAN, SWAP, DONE.
REQ-018 IDLE/DONE: start=1 SHALL latch desc, set i=0, clear counters, go to PASS_INIT; busy rises the next cycle.
REQ-019 PASS_INIT (1 cycle): min_idx<=i, min_val<=mem[i], j<=i+1, go to SCAN.
REQ-020 SCAN (1 cycle per j): cmp_cnt++; if mem[j]<min_val (ascending) or mem[j]>min_val (descending), strictly, then min_idx<=j, min_val<=mem[j]; if j==DEPTH-1 go to SWAP, else j++.
REQ-021 SWAP (1 cycle): if min_idx!=i, write mem[i]<=min_val and mem[min_idx]<=mem[i] on the same edge and swap_cnt++; equal keys SHALL never swap.
REQ-022 From SWAP: if i==DEPTH-2 go to DONE, else i++ and go to PASS_INIT.
REQ-023 busy SHALL last exactly 2(DEPTH-1)+DEPTH(DEPTH-1)/2 cycles (42 for DEPTH=8, 3 for DEPTH=2), independent of data.
REQ-024 done SHALL hold in DONE until start is accepted, or until wr_en is asserted (which returns the FSM to IDLE).
REQ-025 wr_en while busy SHALL be ignored; wr_en in IDLE/DONE SHALL write mem[wr_addr] on the edge.
REQ-026 start while busy SHALL be ignored; desc changes while busy SHALL have no effect.
REQ-027 start and wr_en both high in IDLE/DONE SHALL apply the write first; the sort then sees the written value.
REQ-028 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-029 reset SHALL force IDLE, busy=0, done=0, i=0, j=1, swap_cnt=0, cmp_cnt=0, and all mem entries to 0, including mid-sort.

Configuration
REQ-030 With SEL_SORT_STATS_EN defined, swap_cnt/cmp_cnt SHALL behave per REQ-014/015/020/021/028; without it, both SHALL be constant 0 and no counter registers SHALL be built.

Structure
REQ-031 Package sel_sort_pkg SHALL hold the state enum typedef (sort_state_t) and the counter width constant CNT_W=16.
REQ-032 Storage SHALL be sub-module sel_sort_regfile: DEPTH x DATA_W, async reset, one host write port, one dual-write swap port, two combinational read ports.

Verification
REQ-033 Reset then read all addresses -> rd_data=0, busy=0, done=0, counters 0.
REQ-034 Load [5,3,7,1,6,0,4,2], start with desc=0 -> busy exactly 42 cycles; reads give 0..7; swap_cnt=4, cmp_cnt=28 (STATS_EN).
REQ-035 Same data, desc=1 -> reads give 7,6,5,4,3,2,1,0; busy 42 cycles.
REQ-036 Presorted 0..7 ascending, or all entries 9 -> swap_cnt=0, data unchanged, busy 42 cycles.
REQ-037 During a sort, pulse start and write wr_addr=0 with 8'hFF -> both ignored; result as in REQ-034.
REQ-038 Assert reset 10 cycles into a sort -> immediately busy=0, done=0, all mem reads 0; a new load and sort then completes normally.

Source files
------------

// File: rtl/sel_sort_pkg.sv
// Shared types and constants for the selection-sort engine.
package sel_sort_pkg;

    // Width of the swap / comparison statistics counters.
    localparam int unsigned CNT_W = 16;

    // Sort controller states.
    typedef enum logic [2:0] {
        IDLE,
        PASS_INIT,
        SCAN,
        SWAP,
        DONE
    } sort_state_t;

endpackage

// File: rtl/sel_sort_engine_if.sv
// Host-side bus of the selection-sort engine: control, write port, read port, status.
interface sel_sort_engine_if
    import sel_sort_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              start;
    logic              desc;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  swap_cnt;
    logic [CNT_W-1:0]  cmp_cnt;

    modport master (
        output start, desc, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done, swap_cnt, cmp_cnt
    );

    modport slave (
        input  start, desc, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done, swap_cnt, cmp_cnt
    );

endinterface

// File: rtl/sel_sort_regfile.sv
// Key storage: DEPTH x DATA_W registers with one host write port, one
// dual-write swap port (both entries updated on the same edge) and two
// combinational read ports. Host write and swap are never active together.
module sel_sort_regfile #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              sw_en_i,
    input  logic [IDX_W-1:0]  sw_a_addr_i,
    input  logic [DATA_W-1:0] sw_a_data_i,
    input  logic [IDX_W-1:0]  sw_b_addr_i,
    input  logic [DATA_W-1:0] sw_b_data_i,
    input  logic [IDX_W-1:0]  ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [IDX_W-1:0]  rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage update: clear on reset, otherwise host write or swap pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
            if (sw_en_i) begin
                mem_q[sw_a_addr_i] <= sw_a_data_i;
                mem_q[sw_b_addr_i] <= sw_b_data_i;
            end
        end
    end

    assign ra_data_o = mem_q[ra_addr_i];
    assign rb_data_o = mem_q[rb_addr_i];

endmodule

// File: rtl/sel_sort_engine.sv
// In-place selection sort over DEPTH keys. Each pass scans for the extreme
// key from i+1 upward and performs at most one swap, so run time depends only
// on DEPTH. Define SEL_SORT_STATS_EN to build the swap/comparison counters;
// otherwise swap_cnt and cmp_cnt read as constant zero.
module sel_sort_engine
    import sel_sort_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    sel_sort_engine_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(DEPTH - 2);

    sort_state_t       state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [IDX_W-1:0]  min_idx_q, min_idx_d;
    logic [DATA_W-1:0] min_val_q, min_val_d;
    logic              desc_q, desc_d;

    logic              idle_like;
    logic              accept;
    logic              host_we;
    logic              swap_do;
    logic              better;
    logic [IDX_W-1:0]  int_raddr;
    logic [DATA_W-1:0] int_rdata;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign accept    = idle_like && bus.start;
    assign host_we   = idle_like && bus.wr_en;
    assign swap_do   = (state_q == SWAP) && (min_idx_q != i_q);
    // SCAN reads the candidate at j; PASS_INIT and SWAP both need mem[i].
    assign int_raddr = (state_q == SCAN) ? j_q : i_q;
    assign better    = desc_q ? (int_rdata > min_val_q) : (int_rdata < min_val_q);

    sel_sort_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk         (clk),
        .rst         (reset),
        .wr_en_i     (host_we),
        .wr_addr_i   (bus.wr_addr),
        .wr_data_i   (bus.wr_data),
        .sw_en_i     (swap_do),
        .sw_a_addr_i (i_q),
        .sw_a_data_i (min_val_q),
        .sw_b_addr_i (min_idx_q),
        .sw_b_data_i (int_rdata),
        .ra_addr_i   (int_raddr),
        .ra_data_o   (int_rdata),
        .rb_addr_i   (bus.rd_addr),
        .rb_data_o   (bus.rd_data)
    );

    // Controller state and pass/scan registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= IDX_W'(1);
            min_idx_q <= '0;
            min_val_q <= '0;
            desc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            min_idx_q <= min_idx_d;
            min_val_q <= min_val_d;
            desc_q    <= desc_d;
        end
    end

    // Next-state logic: pass setup, scan for the extreme key, single swap.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        min_idx_d = min_idx_q;
        min_val_d = min_val_q;
        desc_d    = desc_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    desc_d  = bus.desc;
                    i_d     = '0;
                    state_d = PASS_INIT;
                end else if ((state_q == DONE) && bus.wr_en) begin
                    state_d = IDLE;
                end
            end
            PASS_INIT: begin
                min_idx_d = i_q;
                min_val_d = int_rdata;
                j_d       = i_q + IDX_W'(1);
                state_d   = SCAN;
            end
            SCAN: begin
                if (better) begin
                    min_idx_d = j_q;
                    min_val_d = int_rdata;
                end
                if (j_q == LAST_J) begin
                    state_d = SWAP;
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            SWAP: begin
                if (i_q == LAST_I) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + IDX_W'(1);
                    state_d = PASS_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == PASS_INIT) || (state_q == SCAN) || (state_q == SWAP);
    assign bus.done = (state_q == DONE);

`ifdef SEL_SORT_STATS_EN
    logic [CNT_W-1:0] swap_cnt_q, swap_cnt_d;
    logic [CNT_W-1:0] cmp_cnt_q, cmp_cnt_d;

    // Saturating statistics, cleared when a sort is accepted.
    always_comb begin
        swap_cnt_d = swap_cnt_q;
        cmp_cnt_d  = cmp_cnt_q;
        if (accept) begin
            swap_cnt_d = '0;
            cmp_cnt_d  = '0;
        end else begin
            if ((state_q == SCAN) && (cmp_cnt_q != '1)) begin
                cmp_cnt_d = cmp_cnt_q + CNT_W'(1);
            end
            if (swap_do && (swap_cnt_q != '1)) begin
                swap_cnt_d = swap_cnt_q + CNT_W'(1);
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_cnt_q <= '0;
            cmp_cnt_q  <= '0;
        end else begin
            swap_cnt_q <= swap_cnt_d;
            cmp_cnt_q  <= cmp_cnt_d;
        end
    end

    assign bus.swap_cnt = swap_cnt_q;
    assign bus.cmp_cnt  = cmp_cnt_q;
`else
    assign bus.swap_cnt = '0;
    assign bus.cmp_cnt  = '0;
`endif

endmodule
